hw_xtea_avmm: RTL

HW_XTEA_AVMM -- requirements
Module: hw_xtea_avmm

---
 rtl/hw_xtea_pkg.sv | 23 ++
 rtl/hw_xtea_avmm_if.sv | 21 ++
 rtl/hw_xtea_avmm_cycle.sv | 28 ++
 rtl/hw_xtea_avmm.sv | 117 +++++++++++
 4 files changed

// File: rtl/hw_xtea_pkg.sv
// Shared constants, register map and FSM encoding for the XTEA Avalon-MM block.
// Also holds the XTEA mixing term used by both Feistel half-rounds.
package hw_xtea_pkg;

   localparam logic [31:0] DELTA = 32'h9E3779B9;

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_V0     = 3'd2;
   localparam logic [2:0] A_V1     = 3'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   function automatic logic [31:0] mix(input logic [31:0] v);
      return ((v << 4) ^ (v >> 5)) + v;
   endfunction

endpackage

// File: rtl/hw_xtea_avmm_if.sv
// Avalon-MM slave bus bundle; the master holds its command while waitrequest is high.
interface hw_xtea_avmm_if #(
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] address;
   logic              write;
   logic [31:0]       writedata;
   logic              read;
   logic [31:0]       readdata;
   logic              waitrequest;

   modport master (
      output address, write, writedata, read,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, writedata, read,
      output readdata, waitrequest
   );
endinterface

// File: rtl/hw_xtea_avmm_cycle.sv
// One full XTEA cycle (both Feistel half-rounds), purely combinational.
// Encrypt updates v0 then v1 with sum advancing between; decrypt runs the mirror image.
module xtea_cycle
   import hw_xtea_pkg::*;
(
   input  logic [31:0]      v0,
   input  logic [31:0]      v1,
   input  logic [31:0]      sum,
   input  logic [3:0][31:0] key,
   input  logic             mode,
   output logic [31:0]      v0_out,
   output logic [31:0]      v1_out,
   output logic [31:0]      sum_out
);
   logic [31:0] sum_inc, sum_dec, enc_v0, enc_v1, dec_v0, dec_v1;

   always_comb begin
      sum_inc = sum + DELTA;
      sum_dec = sum - DELTA;
      enc_v0  = v0 + (mix(v1) ^ (sum + key[sum[1:0]]));
      enc_v1  = v1 + (mix(enc_v0) ^ (sum_inc + key[sum_inc[12:11]]));
      dec_v1  = v1 - (mix(v0) ^ (sum + key[sum[12:11]]));
      dec_v0  = v0 - (mix(dec_v1) ^ (sum_dec + key[sum_dec[1:0]]));
      v0_out  = mode ? dec_v0 : enc_v0;
      v1_out  = mode ? dec_v1 : enc_v1;
      sum_out = mode ? sum_dec : sum_inc;
   end
endmodule

// File: rtl/hw_xtea_avmm.sv
// XTEA block cipher behind an Avalon-MM slave; done ROUNDS+1 cycles after the start write.
// DATA/KEY accesses stall while busy; reads take one extra cycle; CTRL/STATUS never stall.
module hw_xtea_avmm
   import hw_xtea_pkg::*;
#(
   parameter int ROUNDS = 32,
   parameter int ADDR_W = 3
) (
   input  logic clk,
   input  logic reset,
   hw_xtea_avmm_if.slave bus
);
   localparam int          CNT_W   = 7;
   localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);

   logic [1:0]        rst_sync;
   logic              rst_n;
   state_t            state, state_nxt;
   logic              mode, rd_ack;
   logic [31:0]       v0, v1, sum, nv0, nv1, nsum, rd_val;
   logic [3:0][31:0]  key;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr;
   logic [2:0]        reg_sel;
   logic              in_map, data_acc, busy, last_run;
   logic              wr_stall, rd_stall, wr_en, rd_accept, start;

   // Reset asserts asynchronously but releases on a clock edge, so no flop sees a runt release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign addr     = bus.address;
   assign reg_sel  = addr[2:0];
   assign in_map   = (addr >> 3) == '0;
   assign data_acc = in_map && (reg_sel >= A_V0);
   assign busy     = (state == S_LOAD) || (state == S_RUN);
   assign last_run = (state == S_RUN) && (cnt == CNT_W'(ROUNDS - 1));

   // A read stalled behind the engine is accepted in the final round so its data is the result.
   assign wr_stall  = bus.write && data_acc && busy;
   assign rd_stall  = data_acc && busy && !last_run;
   assign wr_en     = bus.write && !wr_stall;
   assign rd_accept = bus.read && !bus.write && !rd_ack && !rd_stall;
   assign start     = wr_en && in_map && (reg_sel == A_CTRL) && bus.writedata[0] && !busy;
   assign bus.waitrequest = rst_n && (wr_stall || (bus.read && !bus.write && !rd_ack));

   xtea_cycle u_cycle (
      .v0(v0), .v1(v1), .sum(sum), .key(key), .mode(mode),
      .v0_out(nv0), .v1_out(nv1), .sum_out(nsum)
   );

   always_comb begin
      rd_val = '0;
      if (in_map) begin
         case (reg_sel)
            A_CTRL:   rd_val = {30'd0, mode, 1'b0};
            A_STATUS: rd_val = {30'd0, state == S_DONE, busy};
            A_V0:     rd_val = last_run ? nv0 : v0;
            A_V1:     rd_val = last_run ? nv1 : v1;
            default:  rd_val = key[reg_sel[1:0]];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
         S_LOAD:         state_nxt = S_RUN;
         S_RUN:          if (last_run) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode         <= 1'b0;
         rd_ack       <= 1'b0;
         v0           <= '0;
         v1           <= '0;
         sum          <= '0;
         key          <= '0;
         cnt          <= '0;
         bus.readdata <= '0;
      end else begin
         rd_ack <= rd_accept;
         if (rd_accept) bus.readdata <= rd_val;
         if (start) mode <= bus.writedata[1];
         if (state == S_LOAD) begin
            sum <= mode ? SUM_DEC : 32'd0;
            cnt <= '0;
         end
         if (state == S_RUN) begin
            v0  <= nv0;
            v1  <= nv1;
            sum <= nsum;
            cnt <= cnt + 1'b1;
         end
         if (wr_en && in_map) begin
            case (reg_sel)
               A_CTRL, A_STATUS: ;
               A_V0:    v0 <= bus.writedata;
               A_V1:    v1 <= bus.writedata;
               default: key[reg_sel[1:0]] <= bus.writedata;
            endcase
         end
      end
   end
endmodule
